wb_write_arbiter: RTL and testbench

- Writeback-stage block sitting directly upstream of the 32x32 integer/float register file.
- Merges two result streams onto the register file's single write port (one wReg, one write per cycle):
  - the in-order integer pipeline (MEM/WB), which can never stall;
  - the multi-cycle FP unit, which handshakes.
- FP results are buffered in a small FIFO while integer writes hold the port.
- Also enforces r0 immutability, the double-precision write pair rules, and anti-starvation.

---
 rtl/wb_write_arbiter_if.sv | 43 ++++
 rtl/wb_write_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_write_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_write_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_write_arbiter_if: writeback sources, register-file write port and status
// Rev 1.0
// ---------------------------------------------------------------------------
interface wb_write_arbiter_if #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 32
);
  localparam int c_CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                int_valid;
  logic [4:0]          int_reg;
  logic [DATA_W-1:0]   int_data;
  logic                fp_valid;
  logic                fp_ready;
  logic [4:0]          fp_reg;
  logic [DATA_W-1:0]   fp_data;
  logic [DATA_W-1:0]   fp_data2;
  logic                fp_double;
  logic                regWSig;
  logic                regwrite_float;
  logic [4:0]          wReg;
  logic [DATA_W-1:0]   wData;
  logic [DATA_W-1:0]   wData2;
  logic                double;
  logic                stall_req;
  logic [c_CNT_W-1:0]  fifo_count;
  logic                err_double;

  modport master (
    output int_valid, int_reg, int_data, fp_valid, fp_reg, fp_data, fp_data2, fp_double,
    input  fp_ready, regWSig, regwrite_float, wReg, wData, wData2, double,
           stall_req, fifo_count, err_double
  );

  modport slave (
    input  int_valid, int_reg, int_data, fp_valid, fp_reg, fp_data, fp_data2, fp_double,
    output fp_ready, regWSig, regwrite_float, wReg, wData, wData2, double,
           stall_req, fifo_count, err_double
  );
endinterface
`default_nettype wire

// File: rtl/wb_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// wb_write_arbiter: merges the integer writeback and buffered FP results
// onto the single register-file write port. Rev 1.0
// ---------------------------------------------------------------------------
module wb_write_arbiter #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8,
  parameter int DATA_W       = 32
) (
  input wire logic          clk,
  input wire logic          rst_n,
  wb_write_arbiter_if.slave io_wb
);
  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam int c_AGE_W = $clog2(STARVE_LIMIT + 1);

  logic [4:0]         r_q_reg   [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_q_data  [FIFO_DEPTH];
  logic [DATA_W-1:0]  r_q_data2 [FIFO_DEPTH];
  logic               r_q_dbl   [FIFO_DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_AGE_W-1:0] r_age;
  logic               r_regw;
  logic               r_regf;
  logic               r_double;
  logic               r_stall;
  logic               r_err;
  logic [4:0]         r_wreg;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_wdata2;

  logic               w_ready;
  logic               w_empty;
  logic               w_accept;
  logic               w_pop;
  logic               w_bypass;
  logic               w_push;
  logic               w_in_dbl;
  logic [DATA_W-1:0]  w_in_data2;
  logic [c_CNT_W-1:0] w_count_next;
  logic [c_AGE_W-1:0] w_age_next;

  assign w_ready    = r_count < c_CNT_W'(FIFO_DEPTH);
  assign w_empty    = (r_count == '0);
  assign w_accept   = io_wb.fp_valid & w_ready;
  assign w_pop      = ~io_wb.int_valid & ~w_empty;
  assign w_bypass   = ~io_wb.int_valid & w_empty & w_accept;
  assign w_push     = w_accept & ~w_bypass;
  // An odd destination cannot host a register pair, so it degrades to a single write.
  assign w_in_dbl   = io_wb.fp_double & ~io_wb.fp_reg[0];
  assign w_in_data2 = w_in_dbl ? io_wb.fp_data2 : '0;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + c_CNT_W'(1);
    end else if (w_pop && !w_push) begin
      w_count_next = r_count - c_CNT_W'(1);
    end
  end

  always_comb begin
    w_age_next = r_age;
    if (w_empty || w_pop) begin
      w_age_next = '0;
    end else if (r_age != c_AGE_W'(STARVE_LIMIT)) begin
      w_age_next = r_age + c_AGE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_reg[r_wr_ptr]   <= io_wb.fp_reg;
      r_q_data[r_wr_ptr]  <= io_wb.fp_data;
      r_q_data2[r_wr_ptr] <= w_in_data2;
      r_q_dbl[r_wr_ptr]   <= w_in_dbl;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_age    <= '0;
      r_stall  <= 1'b0;
      r_err    <= 1'b0;
      r_regw   <= 1'b0;
      r_regf   <= 1'b0;
      r_double <= 1'b0;
      r_wreg   <= '0;
      r_wdata  <= '0;
      r_wdata2 <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
      r_count <= w_count_next;
      r_age   <= w_age_next;
      r_stall <= (w_age_next == c_AGE_W'(STARVE_LIMIT));
      if (w_accept && io_wb.fp_double && io_wb.fp_reg[0]) r_err <= 1'b1;

      r_regw   <= 1'b0;
      r_regf   <= 1'b0;
      r_double <= 1'b0;
      if (io_wb.int_valid) begin
        // Writes to r0 are swallowed: the slot is still spent on the integer result.
        if (io_wb.int_reg != 5'd0) begin
          r_regw   <= 1'b1;
          r_wreg   <= io_wb.int_reg;
          r_wdata  <= io_wb.int_data;
          r_wdata2 <= '0;
        end
      end else if (w_pop) begin
        r_regf   <= 1'b1;
        r_wreg   <= r_q_reg[r_rd_ptr];
        r_wdata  <= r_q_data[r_rd_ptr];
        r_wdata2 <= r_q_data2[r_rd_ptr];
        r_double <= r_q_dbl[r_rd_ptr];
      end else if (w_bypass) begin
        r_regf   <= 1'b1;
        r_wreg   <= io_wb.fp_reg;
        r_wdata  <= io_wb.fp_data;
        r_wdata2 <= w_in_data2;
        r_double <= w_in_dbl;
      end
    end
  end

  assign io_wb.fp_ready       = w_ready;
  assign io_wb.regWSig        = r_regw;
  assign io_wb.regwrite_float = r_regf;
  assign io_wb.wReg           = r_wreg;
  assign io_wb.wData          = r_wdata;
  assign io_wb.wData2         = r_wdata2;
  assign io_wb.double         = r_double;
  assign io_wb.stall_req      = r_stall;
  assign io_wb.fifo_count     = r_count;
  assign io_wb.err_double     = r_err;
endmodule
`default_nettype wire

// File: tb/tb_wb_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_wb_write_arbiter: scoreboard bench for the writeback write arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_wb_write_arbiter;
  localparam int c_DEPTH = 4;
  localparam int c_LIMIT = 8;
  localparam int c_DW    = 32;

  typedef struct packed {
    logic [4:0]  r;
    logic [31:0] d;
    logic [31:0] d2;
    logic        dbl;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   m_cnt  = 0;
  wr_t  int_q[$];
  wr_t  fp_q[$];

  always #5 clk = ~clk;

  wb_write_arbiter_if #(.FIFO_DEPTH(c_DEPTH), .DATA_W(c_DW)) bus ();

  wb_write_arbiter #(
    .FIFO_DEPTH  (c_DEPTH),
    .STARVE_LIMIT(c_LIMIT),
    .DATA_W      (c_DW)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io_wb(bus.slave)
  );

  // Every observed write must match the head of its stream's expectation queue.
  always @(negedge clk) begin
    wr_t got;
    wr_t exp;
    if (bus.regWSig === 1'b1 && bus.regwrite_float === 1'b1) begin
      checks++; errors++;
      $display("FAIL both_enables: regWSig and regwrite_float asserted together");
    end
    if (bus.regWSig === 1'b1) begin
      checks++;
      got = {bus.wReg, bus.wData, 32'h0, bus.double};
      if (int_q.size() == 0) begin
        errors++;
        $display("FAIL int_unexpected: got reg=%0d data=%h, required no integer write", bus.wReg, bus.wData);
      end else begin
        exp = int_q.pop_front();
        if (got !== exp)begin
          errors++;
          $display("FAIL int_write: got reg=%0d data=%h dbl=%b, required reg=%0d data=%h dbl=0",
                   got.r, got.d, got.dbl, exp.r, exp.d);
        end
      end
    end
    if (bus.regwrite_float === 1'b1) begin
      checks++;
      got = {bus.wReg, bus.wData, bus.wData2, bus.double};
      if (fp_q.size() == 0) begin
        errors++;
        $display("FAIL fp_unexpected: got reg=%0d data=%h, required no float write", bus.wReg, bus.wData);
      end else begin
        exp = fp_q.pop_front();
        if (got !== exp) begin
          errors++;
          $display("FAIL fp_write: got reg=%0d d=%h d2=%h dbl=%b, required reg=%0d d=%h d2=%h dbl=%b",
                   got.r, got.d, got.d2, got.dbl, exp.r, exp.d, exp.d2, exp.dbl);
        end
      end
    end
  end

  // Drives one cycle of stimulus, records expected writes, and returns on the next negedge.
  task automatic cycle(input logic iv, input logic [4:0] ir, input logic [31:0] id,
                       input logic fv, input logic [4:0] fr, input logic [31:0] fd,
                       input logic [31:0] fd2, input logic fdbl, output logic acc);
    logic pop;
    logic byp;
    logic dbl;
    bus.int_valid = iv;
    bus.int_reg   = ir;
    bus.int_data  = id;
    bus.fp_valid  = fv;
    bus.fp_reg    = fr;
    bus.fp_data   = fd;
    bus.fp_data2  = fd2;
    bus.fp_double = fdbl;
    acc = fv && (m_cnt < c_DEPTH);
    dbl = fdbl && !fr[0];
    if (iv && ir != 5'd0) int_q.push_back({ir, id, 32'h0, 1'b0});
    if (acc) fp_q.push_back({fr, fd, dbl ? fd2 : 32'h0, dbl});
    pop   = !iv && m_cnt > 0;
    byp   = !iv && m_cnt == 0 && acc;
    m_cnt = m_cnt + ((acc && !byp) ? 1 : 0) - (pop ? 1 : 0);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, acc);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.int_valid = 1'b0;
    bus.int_reg   = 5'd0;
    bus.int_data  = '0;
    bus.fp_valid  = 1'b0;
    bus.fp_reg    = 5'd0;
    bus.fp_data   = '0;
    bus.fp_data2  = '0;
    bus.fp_double = 1'b0;
    #1;
    int_q.delete();
    fp_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({bus.regWSig, bus.regwrite_float, bus.double, bus.stall_req, bus.err_double} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b, required 00000",
               {bus.regWSig, bus.regwrite_float, bus.double, bus.stall_req, bus.err_double});
    end
    checks++;
    if ({bus.wReg, bus.wData, bus.wData2} !== 69'h0) begin
      errors++;
      $display("FAIL reset_data: got reg=%0d d=%h d2=%h, required zeros", bus.wReg, bus.wData, bus.wData2);
    end
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.fp_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_fifo: got count=%0d ready=%b, required count=0 ready=1", bus.fifo_count, bus.fp_ready);
    end
  endtask

  task automatic test_int_write();
    logic acc;
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    checks++;
    if (bus.regWSig !== 1'b1 || bus.wReg !== 5'd5 || bus.wData !== 32'hDEADBEEF || bus.regwrite_float !== 1'b0) begin
      errors++;
      $display("FAIL int_basic: got we=%b reg=%0d data=%h fwe=%b, required we=1 reg=5 data=deadbeef fwe=0",
               bus.regWSig, bus.wReg, bus.wData, bus.regwrite_float);
    end
    idle(1);
    checks++;
    if (bus.regWSig !== 1'b0) begin
      errors++;
      $display("FAIL int_pulse: got regWSig=%b, required 0", bus.regWSig);
    end
  endtask

  task automatic test_int_r0();
    logic acc;
    cycle(1'b1, 5'd0, 32'h00001234, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, acc);
    checks++;
    if (bus.regWSig !== 1'b0 || bus.regwrite_float !== 1'b0) begin
      errors++;
      $display("FAIL int_r0: got we=%b fwe=%b, required we=0 fwe=0", bus.regWSig, bus.regwrite_float);
    end
  endtask

  task automatic test_bypass_double();
    logic acc;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 32'h3F800000, 32'h40000000, 1'b1, acc);
    checks++;
    if (bus.regwrite_float !== 1'b1 || bus.double !== 1'b1 || bus.wReg !== 5'd2 ||
        bus.wData !== 32'h3F800000 || bus.wData2 !== 32'h40000000) begin
      errors++;
      $display("FAIL bypass: got fwe=%b dbl=%b reg=%0d d=%h d2=%h, required 1 1 2 3f800000 40000000",
               bus.regwrite_float, bus.double, bus.wReg, bus.wData, bus.wData2);
    end
    checks++;
    if (bus.fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL bypass_count: got %0d, required 0", bus.fifo_count);
    end
  endtask

  task automatic test_fifo_full();
    logic acc;
    int   k;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      if (c == 4) begin
        checks++;
        if (bus.fp_ready !== 1'b0 || bus.fifo_count !== 3'd4) begin
          errors++;
          $display("FAIL full: got ready=%b count=%0d, required ready=0 count=4", bus.fp_ready, bus.fifo_count);
        end
      end
      cycle(1'b1, 5'(10 + c), 32'hA0000000 + c, 1'b1, 5'(4 + 2 * k), 32'h10000000 + k,
            32'h20000000 + k, k[0], acc);
      if (acc) k++;
      checks++;
      if (bus.regWSig !== 1'b1) begin
        errors++;
        $display("FAIL full_int_%0d: got regWSig=%b, required 1", c, bus.regWSig);
      end
    end
    for (int c = 0; c < 7; c++) begin
      cycle(1'b0, 5'd0, 32'h0, (k < 5) ? 1'b1 : 1'b0, 5'(4 + 2 * k), 32'h10000000 + k,
            32'h20000000 + k, k[0], acc);
      if (acc) k++;
      checks++;
      if (bus.regwrite_float !== ((c < 5) ? 1'b1 : 1'b0) || bus.fifo_count !== 3'(m_cnt)) begin
        errors++;
        $display("FAIL drain_%0d: got fwe=%b count=%0d, required fwe=%b count=%0d",
                 c, bus.regwrite_float, bus.fifo_count, (c < 5) ? 1'b1 : 1'b0, m_cnt);
      end
    end
  endtask

  task automatic test_starve();
    logic acc;
    cycle(1'b1, 5'd7, 32'h77770000, 1'b1, 5'd9, 32'h99990000, 32'h0, 1'b0, acc);
    for (int i = 0; i < c_LIMIT; i++) begin
      cycle(1'b1, 5'd7, 32'h77770001 + i, 1'b0, 5'd0, 32'h0, 32'h0, 1'b0, acc);
      checks++;
      if (bus.stall_req !== ((i == c_LIMIT - 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL starve_%0d: got stall_req=%b, required %b", i, bus.stall_req,
                 (i == c_LIMIT - 1) ? 1'b1 : 1'b0);
      end
    end
    idle(1);
    checks++;
    if (bus.regwrite_float !== 1'b1 || bus.stall_req !== 1'b0 || bus.wReg !== 5'd9) begin
      errors++;
      $display("FAIL starve_release: got fwe=%b stall=%b reg=%0d, required fwe=1 stall=0 reg=9",
               bus.regwrite_float, bus.stall_req, bus.wReg);
    end
  endtask

  task automatic test_odd_double_and_reset();
    logic acc;
    cycle(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 32'h31313131, 32'hBADBAD00, 1'b1, acc);
    checks++;
    if (bus.regwrite_float !== 1'b1 || bus.wReg !== 5'd31 || bus.double !== 1'b0 ||
        bus.wData2 !== 32'h0 || bus.err_double !== 1'b1) begin
      errors++;
      $display("FAIL odd_double: got fwe=%b reg=%0d dbl=%b d2=%h err=%b, required 1 31 0 0 1",
               bus.regwrite_float, bus.wReg, bus.double, bus.wData2, bus.err_double);
    end
    for (int i = 0; i < 3; i++) cycle(1'b1, 5'd3, 32'h3000 + i, 1'b1, 5'(20 + i), 32'h5000 + i, 32'h0, 1'b0, acc);
    checks++;
    if (bus.fifo_count !== 3'd3 || bus.err_double !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got count=%0d err=%b, required count=3 err=1", bus.fifo_count, bus.err_double);
    end
    do_reset();
    checks++;
    if (bus.fifo_count !== 3'd0 || bus.err_double !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got count=%0d err=%b, required count=0 err=0", bus.fifo_count, bus.err_double);
    end
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (bus.regwrite_float !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_%0d: got regwrite_float=%b, required 0", i, bus.regwrite_float);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_int_write();
    test_int_r0();
    test_bypass_double();
    test_fifo_full();
    test_starve();
    test_odd_double_and_reset();
    idle(2);
    checks++;
    if (int_q.size() != 0 || fp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover: got int=%0d fp=%0d pending writes, required 0 0", int_q.size(), fp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
